// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers one CPU load/store at a time after a
// fixed number of wait cycles, flagging misaligned or out-of-range requests.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [3:0]  be_in,
  input  logic [31:0] wdata_in,
  output logic        ack_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        busy_out,
  output logic [15:0] txn_count_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic          cap_we;
  logic          cap_err;
  logic [3:0]    cap_be;
  logic [31:0]   cap_wdata;
  logic [AW-1:0] cap_idx;
  logic [15:0]   txn_count;
  logic          req_err;
  logic          store_ok;

  logic [31:0] mem [DEPTH];

  // The error decision is taken on the live address at capture time.
  assign req_err  = (addr_in[1:0] != 2'b00) || (addr_in >= 32'(4 * DEPTH));
  assign store_ok = (state == RESP) && cap_we && !cap_err;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (req_in) begin
          wait_cnt_nxt = 4'(WAIT_CYCLES);
          state_nxt    = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        wait_cnt_nxt = 4'd0;
        state_nxt    = IDLE;
      end
      default: begin
        wait_cnt_nxt = 4'd0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      txn_count <= 16'd0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_be    <= 4'd0;
      cap_wdata <= 32'd0;
      cap_idx   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == IDLE && req_in) begin
        cap_we    <= we_in;
        cap_err   <= req_err;
        cap_be    <= be_in;
        cap_wdata <= wdata_in;
        cap_idx   <= addr_in[AW+1:2];
      end
      if (state == RESP) txn_count <= txn_count + 16'd1;
    end
  end

  // Storage is deliberately not reset; a reset also suppresses a pending store.
  always_ff @(posedge clk_in) begin
    if (!rst_in && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

  assign ack_out       = (state == RESP);
  assign busy_out      = (state != IDLE);
  assign err_out       = ack_out && cap_err;
  assign rdata_out     = (ack_out && !cap_we && !cap_err) ? mem[cap_idx] : 32'd0;
  assign txn_count_out = txn_count;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with two wait cycles,
// one with zero wait cycles, sharing the request payload signals.
module tb_data_mem_responder;

  typedef struct {
    logic        z;
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    bit          scr;
    int          lat;
  } stim_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_z = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be = 4'd0;

  logic        ack_a, err_a, busy_a, ack_z, err_z, busy_z;
  logic [31:0] rdata_a, rdata_z;
  logic [15:0] cnt_a, cnt_z;

  logic        use_z = 1'b0;
  logic        ack_s, err_s, busy_s;
  logic [31:0] rdata_s;
  logic [15:0] cnt_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [2][64];
  logic [15:0] model_cnt_a = 16'd0, model_cnt_z = 16'd0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .req_in(req_a), .we_in(we), .addr_in(addr),
    .be_in(be), .wdata_in(wdata), .ack_out(ack_a), .rdata_out(rdata_a),
    .err_out(err_a), .busy_out(busy_a), .txn_count_out(cnt_a)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clk_in(clk), .rst_in(rst), .req_in(req_z), .we_in(we), .addr_in(addr),
    .be_in(be), .wdata_in(wdata), .ack_out(ack_z), .rdata_out(rdata_z),
    .err_out(err_z), .busy_out(busy_z), .txn_count_out(cnt_z)
  );

  assign ack_s   = use_z ? ack_z   : ack_a;
  assign err_s   = use_z ? err_z   : err_a;
  assign busy_s  = use_z ? busy_z  : busy_a;
  assign rdata_s = use_z ? rdata_z : rdata_a;
  assign cnt_s   = use_z ? cnt_z   : cnt_a;

  // Reference model: decide error/data and update the model memory and count.
  task automatic predict(input stim_t s);
    exp_t e;
    int   zi;
    int   idx;
    zi      = s.z ? 1 : 0;
    idx     = int'(s.a[7:2]);
    e.err   = (s.a[1:0] != 2'b00) || (s.a >= 32'd256);
    e.rdata = (!s.w && !e.err) ? model_mem[zi][idx] : 32'h0;
    if (s.w && !e.err) begin
      for (int i = 0; i < 4; i++) begin
        if (s.b[i]) model_mem[zi][idx][8*i +: 8] = s.d[8*i +: 8];
      end
    end
    if (s.z) model_cnt_z = model_cnt_z + 16'd1;
    else     model_cnt_a = model_cnt_a + 16'd1;
    e.cnt = s.z ? model_cnt_z : model_cnt_a;
    sb.push_back(e);
  endtask

  task automatic issue(input stim_t s, output int lat, output logic oe,
                       output logic [31:0] od, output logic [15:0] oc,
                       output logic hs_ok);
    predict(s);
    lat   = 0;
    oe    = 1'bx;
    od    = 32'hxxxx_xxxx;
    hs_ok = 1'b1;
    @(negedge clk);
    use_z = s.z;
    we    = s.w;
    addr  = s.a;
    be    = s.b;
    wdata = s.d;
    if (s.z) req_z = 1'b1;
    else     req_a = 1'b1;
    @(posedge clk);
    #1;
    if (s.scr) begin
      we    = ~s.w;
      addr  = s.a ^ 32'h0000_0004;
      be    = ~s.b;
      wdata = ~s.d;
    end
    for (int c = 1; c <= 40; c++) begin
      if (busy_s !== 1'b1) hs_ok = 1'b0;
      if (ack_s === 1'b1) begin
        lat = c;
        oe  = err_s;
        od  = rdata_s;
        break;
      end
      @(posedge clk);
      #1;
    end
    req_a = 1'b0;
    req_z = 1'b0;
    @(posedge clk);
    #1;
    oc = cnt_s;
    if (busy_s !== 1'b0 || ack_s !== 1'b0 || rdata_s !== 32'd0) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_a = 1'b1;
    we    = 1'b0;
    addr  = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({ack_a, busy_a, err_a, rdata_a, cnt_a} !== 51'd0)
      $display("[TB] FAIL reset_a: got ack=%b busy=%b err=%b rdata=%h cnt=%h, want all 0",
               ack_a, busy_a, err_a, rdata_a, cnt_a);
    else pass_cnt++;
    total_cnt++;
    if ({ack_z, busy_z, err_z, rdata_z, cnt_z} !== 51'd0)
      $display("[TB] FAIL reset_z: got ack=%b busy=%b err=%b rdata=%h cnt=%h, want all 0",
               ack_z, busy_z, err_z, rdata_z, cnt_z);
    else pass_cnt++;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_cnt_a = 16'd0;
    model_cnt_z = 16'd0;
  endtask

  task automatic test_store_load();
    stim_t tbl[$];
    exp_t e;
    int lat;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    tbl.push_back('{1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 3});
    foreach (tbl[k]) begin
      issue(tbl[k], lat, oe, od, oc, hs);
      e = sb.pop_front();
      total_cnt++;
      if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
        $display("[TB] FAIL store_load resp %0d: got err=%b rdata=%h cnt=%0d, want err=%b rdata=%h cnt=%0d",
                 k, oe, od, oc, e.err, e.rdata, e.cnt);
      else pass_cnt++;
      total_cnt++;
      if (lat !== tbl[k].lat || hs !== 1'b1)
        $display("[TB] FAIL store_load timing %0d: got lat=%0d hs=%b, want lat=%0d hs=1",
                 k, lat, hs, tbl[k].lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_byte_enable();
    stim_t tbl[$];
    exp_t e;
    int lat;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    tbl.push_back('{1'b0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h10, 4'b0000, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 4'b0000, 32'h12345678, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h10, 4'b0000, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 4'b1010, 32'h11223344, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h10, 4'b0000, 32'h0,        1'b0, 3});
    foreach (tbl[k]) begin
      issue(tbl[k], lat, oe, od, oc, hs);
      e = sb.pop_front();
      total_cnt++;
      if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
        $display("[TB] FAIL byte_enable resp %0d: got err=%b rdata=%h cnt=%0d, want err=%b rdata=%h cnt=%0d",
                 k, oe, od, oc, e.err, e.rdata, e.cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    stim_t tbl[$];
    exp_t e;
    int lat;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    tbl.push_back('{1'b0, 1'b0, 32'h12,  4'hF, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 32'h11,  4'hF, 32'h0BAD0BAD, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 32'hFC,  4'hF, 32'h5A5A5A5A, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'hFC,  4'hF, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 32'h0,   4'hF, 32'h0,        1'b0, 3});
    tbl[7].a = 32'h8000_0010;
    foreach (tbl[k]) begin
      issue(tbl[k], lat, oe, od, oc, hs);
      e = sb.pop_front();
      total_cnt++;
      if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
        $display("[TB] FAIL errors resp %0d: got err=%b rdata=%h cnt=%0d, want err=%b rdata=%h cnt=%0d",
                 k, oe, od, oc, e.err, e.rdata, e.cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold(input logic z);
    stim_t tbl[$];
    exp_t e;
    int lat;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    int want_lat;
    want_lat = z ? 1 : 3;
    tbl.push_back('{z, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b1, want_lat});
    tbl.push_back('{z, 1'b1, 32'h44, 4'hF, 32'h01020304, 1'b0, want_lat});
    tbl.push_back('{z, 1'b0, 32'h40, 4'hF, 32'h0,        1'b1, want_lat});
    tbl.push_back('{z, 1'b0, 32'h44, 4'hF, 32'h0,        1'b0, want_lat});
    foreach (tbl[k]) begin
      issue(tbl[k], lat, oe, od, oc, hs);
      e = sb.pop_front();
      total_cnt++;
      if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
        $display("[TB] FAIL hold%0b resp %0d: got err=%b rdata=%h cnt=%0d, want err=%b rdata=%h cnt=%0d",
                 z, k, oe, od, oc, e.err, e.rdata, e.cnt);
      else pass_cnt++;
      total_cnt++;
      if (lat !== tbl[k].lat || hs !== 1'b1)
        $display("[TB] FAIL hold%0b timing %0d: got lat=%0d hs=%b, want lat=%0d hs=1",
                 z, k, lat, hs, tbl[k].lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t e;
    int first, second;
    s = '{1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 3};
    predict(s);
    predict(s);
    first  = 0;
    second = 0;
    @(negedge clk);
    use_z = 1'b0;
    we    = 1'b0;
    addr  = 32'h10;
    be    = 4'hF;
    req_a = 1'b1;
    for (int c = 1; c <= 30 && second == 0; c++) begin
      @(posedge clk);
      #1;
      if (ack_a === 1'b1) begin
        if (first == 0) first = c;
        else begin
          second = c;
          req_a  = 1'b0;
        end
        e = sb.pop_front();
        total_cnt++;
        if ({err_a, rdata_a} !== {e.err, e.rdata})
          $display("[TB] FAIL b2b resp: got err=%b rdata=%h, want err=%b rdata=%h",
                   err_a, rdata_a, e.err, e.rdata);
        else pass_cnt++;
      end
    end
    req_a = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (second - first !== 4 || second == 0)
      $display("[TB] FAIL b2b spacing: got acks at %0d and %0d, want 4 cycles apart", first, second);
    else pass_cnt++;
    total_cnt++;
    if (cnt_a !== model_cnt_a)
      $display("[TB] FAIL b2b count: got %0d, want %0d", cnt_a, model_cnt_a);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_reset_abort();
    stim_t s;
    exp_t e;
    int lat, acks;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    s = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h11111111, 1'b0, 3};
    issue(s, lat, oe, od, oc, hs);
    e = sb.pop_front();
    @(negedge clk);
    use_z = 1'b0;
    we    = 1'b1;
    addr  = 32'h20;
    be    = 4'hF;
    wdata = 32'h22222222;
    req_a = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (busy_a !== 1'b1)
      $display("[TB] FAIL abort busy_set: got %b, want 1", busy_a);
    else pass_cnt++;
    @(negedge clk);
    req_a = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({busy_a, ack_a, cnt_a} !== 18'd0)
      $display("[TB] FAIL abort cleared: got busy=%b ack=%b cnt=%0d, want 0 0 0", busy_a, ack_a, cnt_a);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    model_cnt_a = 16'd0;
    model_cnt_z = 16'd0;
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ack_a === 1'b1) acks++;
    end
    total_cnt++;
    if (acks !== 0)
      $display("[TB] FAIL abort no_ack: got %0d acks, want 0", acks);
    else pass_cnt++;
    s = '{1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 3};
    issue(s, lat, oe, od, oc, hs);
    e = sb.pop_front();
    total_cnt++;
    if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
      $display("[TB] FAIL abort reload: got err=%b rdata=%h cnt=%0d, want err=%b rdata=%h cnt=%0d",
               oe, od, oc, e.err, e.rdata, e.cnt);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    stim_t s;
    exp_t e;
    int lat;
    logic oe, hs;
    logic [31:0] od;
    logic [15:0] oc;
    @(negedge clk);
    force dut_z.txn_count = 16'hFFFE;
    #1;
    release dut_z.txn_count;
    model_cnt_z = 16'hFFFE;
    s = '{1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1};
    for (int k = 0; k < 2; k++) begin
      issue(s, lat, oe, od, oc, hs);
      e = sb.pop_front();
      total_cnt++;
      if ({oe, od, oc} !== {e.err, e.rdata, e.cnt})
        $display("[TB] FAIL wrap resp %0d: got err=%b rdata=%h cnt=%h, want err=%b rdata=%h cnt=%h",
                 k, oe, od, oc, e.err, e.rdata, e.cnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_hold(1'b0);
    test_back_to_back();
    test_reset_abort();
    test_hold(1'b1);
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, the number of 32-bit words of storage (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the wait cycles inserted between request capture and response (0..15).
REQ-003 clk_in  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 req_in  input  1  CPU asserts to request a load or store; held until ack_out.
REQ-006 we_in  input  1  1 = store, 0 = load; sampled with req_in.
REQ-007 addr_in  input  32  byte address; word index = addr_in[log2(DEPTH)+1:2].
REQ-008 be_in  input  4  byte enables for stores; bit i selects wdata_in[8i+7:8i].
REQ-009 wdata_in  input  32  store data.
REQ-010 ack_out  output  1  one-cycle pulse marking the response cycle.
REQ-011 rdata_out  output  32  load data; valid only while ack_out=1 on a load.
REQ-012 err_out  output  1  valid with ack_out; 1 = request rejected.
REQ-013 busy_out  output  1  1 from request capture until the ack cycle inclusive.
REQ-014 txn_count_out  output  16  count of acknowledged transactions, errors included.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP.
REQ-016 IDLE: on req_in=1, SHALL capture we_in, addr_in, be_in and wdata_in, and load the wait counter with WAIT_CYCLES.
REQ-017 In IDLE with a captured request, SHALL go to RESP if WAIT_CYCLES=0, otherwise to WAIT.
REQ-018 WAIT: SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-019 Latency SHALL be WAIT_CYCLES+1 cycles from the capture edge to the ack_out=1 cycle; with WAIT_CYCLES=2, ack_out is high in the 3rd cycle after capture.
REQ-020 RESP: SHALL drive ack_out=1 for exactly one cycle, then return to IDLE.
REQ-021 Inputs SHALL be ignored outside IDLE; the captured request stays valid even if the CPU changes inputs.
REQ-022 A new request SHALL be captured no earlier than the cycle after ack_out; minimum back-to-back spacing is WAIT_CYCLES+2 cycles.
REQ-023 Error condition: err_out=1 if addr_in[1:0]!=0 (misaligned) or addr_in >= 4*DEPTH (out of range).
REQ-024 A store SHALL write memory on the RESP edge only when err is 0, and only the bytes whose be_in bit is set.
REQ-025 A store with be_in=0000 SHALL ack with err_out=0 and leave memory unchanged.
REQ-026 A load SHALL drive rdata_out with the addressed word during RESP when err is 0.
REQ-027 rdata_out SHALL be 0 on errors, on stores, and whenever ack_out=0.
REQ-028 txn_count_out SHALL increment on every ack and wrap from 16'hFFFF to 0.
REQ-029 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-030 rst_in=1 SHALL force, on the next edge: state IDLE, ack_out=0, err_out=0, busy_out=0, rdata_out=0, txn_count_out=0, wait counter 0.
REQ-031 Reset SHALL take priority over every other event, including a request in the same cycle.
REQ-032 Reset mid-transaction (WAIT or RESP) SHALL abort the request: no ack is issued, and a pending store is not written.

Verification
REQ-033 Store then load, WAIT_CYCLES=2: store 0xDEADBEEF at addr 0x10 with be=1111, then load 0x10 -> ack in the 3rd cycle after each capture, load rdata_out=0xDEADBEEF, err_out=0, txn_count_out=2.
REQ-034 Byte-enable merge: with 0xDEADBEEF at 0x10, store 0x000000AA with be=0001, then load 0x10 -> rdata_out=0xDEADBEAA.
REQ-035 Errors: load 0x12 -> ack with err_out=1, rdata_out=0; store to 0x100 with DEPTH=64 -> err_out=1 and memory unchanged; txn_count_out increments on both.
REQ-036 Reset abort: assert rst_in during WAIT of a store to 0x20 -> no ack, busy_out=0 next cycle, a later load of 0x20 returns its prior value.
REQ-037 Zero-wait and hold: WAIT_CYCLES=0 gives ack in the cycle after capture; changing addr_in/wdata_in during busy_out=1 does not alter the response.
REQ-038 Counter wrap: preload by 65535 acks, then one more ack -> txn_count_out=0.
